// File: rtl/if_prefetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch prefetch queue.
// Imported by the interface, the FIFO sub-module and the top level.
package if_prefetch_queue_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Fetch FSM: IDLE (no request outstanding), WAIT (request outstanding,
    // response will be kept), DROP (request outstanding, response is stale)
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } ifq_state_t;

    // One queue entry: the fetch address and the word returned for it
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } ifq_entry_t;

    // Branch targets are word aligned; the low two bits are cleared
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_prefetch_queue_if.sv
// Bus bundle of the prefetch queue: redirect input, IF/ID handshake and
// the instruction-memory request/response channel.
// master = prefetch queue side, slave = pipeline / memory side.
interface if_prefetch_queue_if;
    import if_prefetch_queue_pkg::*;

    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            if_ready;
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_instr;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        input  redirect, redirect_pc, if_ready, imem_rvalid, imem_rdata,
        output if_valid, if_pc, if_instr, imem_req, imem_addr
    );

    modport slave (
        output redirect, redirect_pc, if_ready, imem_rvalid, imem_rdata,
        input  if_valid, if_pc, if_instr, imem_req, imem_addr
    );

endinterface

// File: rtl/if_prefetch_queue_fifo.sv
// ifq_fifo: DEPTH-entry circular buffer of {pc,instr} pairs.
// Flush empties the buffer and overrides push/pop in the same cycle.
// Storage is not reset; only pointers and occupancy are.
module ifq_fifo
    import if_prefetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  ifq_entry_t               wdata,
    output ifq_entry_t               head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;
    localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

    ptr_t       wr_ptr_q, wr_ptr_d;
    ptr_t       rd_ptr_q, rd_ptr_d;
    cnt_t       count_q, count_d;
    ifq_entry_t mem_q [DEPTH];
    logic       do_push;
    logic       do_pop;

    // Next pointer/occupancy; pointers wrap naturally because DEPTH is 2^PW
    always_comb begin
        do_push  = push && (count_q != FULL_CNT);
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + cnt_t'(1);
                2'b01:   count_d = count_q - cnt_t'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; a flushed push is simply not written
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue: instruction-fetch front end with a prefetch FIFO.
// Issues sequential fetches (one outstanding at most) to a variable-latency
// instruction memory, buffers {pc,instr} pairs and hands them to IF/ID under
// valid/ready. A redirect flushes the queue and restarts fetching.
// Optional feature: define IFQ_PERF_EN to add saturating perf counters
// perf_flush_cnt (redirect cycles) and perf_starve_cnt (if_ready & !if_valid).
module if_prefetch_queue
    import if_prefetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                   clk,
    input  logic                   reset,
    if_prefetch_queue_if.master    bus,
    output logic [$clog2(DEPTH):0] ifq_count
`ifdef IFQ_PERF_EN
    ,
    output logic [31:0]            perf_flush_cnt,
    output logic [31:0]            perf_starve_cnt
`else
`endif
);

    localparam int PW = $clog2(DEPTH);
    typedef logic [PW:0] cnt_t;
    localparam cnt_t FULL_CNT    = cnt_t'(DEPTH);
    localparam cnt_t LAST_SLOT   = cnt_t'(DEPTH - 1);

    ifq_state_t      state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            req_w;
    logic [XLEN-1:0] addr_w;
    logic            push;
    logic            pop;
    logic            flush;
    logic            room_after_push;
    logic            if_valid_w;
    cnt_t            fifo_count;
    ifq_entry_t      push_entry;
    ifq_entry_t      head;

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (push_entry),
        .head  (head),
        .count (fifo_count)
    );

    assign if_valid_w       = (fifo_count != '0);
    // A redirect discards whatever IF/ID would have taken this cycle
    assign pop              = if_valid_w && bus.if_ready && !bus.redirect;
    // After a push, is there still a free slot to reserve for the next fetch?
    assign room_after_push  = pop || (fifo_count < LAST_SLOT);
    assign push_entry.pc    = fetch_pc_q;
    assign push_entry.instr = bus.imem_rdata;

    // Fetch FSM next state, fetch address and request; redirect wins over all
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_w      = 1'b0;
        addr_w     = fetch_pc_q;
        push       = 1'b0;
        flush      = 1'b0;
        if (bus.redirect) begin
            flush      = 1'b1;
            fetch_pc_d = align_pc(bus.redirect_pc);
            case (state_q)
                // A response arriving now is consumed and dropped, so nothing
                // remains outstanding; otherwise the late one must be dropped.
                WAIT:    state_d = bus.imem_rvalid ? IDLE : DROP;
                DROP:    state_d = bus.imem_rvalid ? IDLE : DROP;
                default: state_d = IDLE;
            endcase
        end else begin
            case (state_q)
                IDLE: begin
                    if (fifo_count != FULL_CNT) begin
                        req_w   = 1'b1;
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_rvalid) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        if (room_after_push) begin
                            req_w  = 1'b1;
                            addr_w = fetch_pc_q + 32'd4;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                DROP: begin
                    if (bus.imem_rvalid) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM state and fetch address registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // No request may leave while the core (and memory) are held in reset
    assign bus.imem_req  = req_w && reset;
    assign bus.imem_addr = addr_w;
    assign bus.if_valid  = if_valid_w;
    assign bus.if_pc     = if_valid_w ? head.pc : '0;
    assign bus.if_instr  = if_valid_w ? head.instr : NOP_INSTR;
    assign ifq_count     = fifo_count;

`ifdef IFQ_PERF_EN
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] starve_cnt_q, starve_cnt_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Count redirect cycles and cycles where IF/ID waits on an empty queue
    always_comb begin
        flush_cnt_d  = flush_cnt_q;
        starve_cnt_d = starve_cnt_q;
        if (bus.redirect)                 flush_cnt_d  = sat_inc(flush_cnt_q);
        if (bus.if_ready && !if_valid_w)  starve_cnt_d = sat_inc(starve_cnt_q);
    end

    // Perf counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush_cnt_q  <= '0;
            starve_cnt_q <= '0;
        end else begin
            flush_cnt_q  <= flush_cnt_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign perf_flush_cnt  = flush_cnt_q;
    assign perf_starve_cnt = starve_cnt_q;
`else
    // Perf counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Testbench for if_prefetch_queue: directed phases drive redirect/if_ready,
// a memory model answers fetches with a configurable latency, and a monitor
// compares every accepted IF/ID entry against a queue of expected PCs.
module tb_if_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic [$clog2(DEPTH):0] ifq_count;
`ifdef IFQ_PERF_EN
    logic [31:0] perf_flush_cnt;
    logic [31:0] perf_starve_cnt;
`else
`endif

    if_prefetch_queue_if bus ();

    if_prefetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .ifq_count (ifq_count)
`ifdef IFQ_PERF_EN
        ,
        .perf_flush_cnt  (perf_flush_cnt),
        .perf_starve_cnt (perf_starve_cnt)
`else
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q [$];
    int          lat = 1;

    // Memory contents: each word is its address with a fixed pattern folded in
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Instruction memory: request seen in cycle N answers in cycle N+lat
    logic        m_pend = 1'b0;
    int          m_cnt  = 0;
    logic [31:0] m_addr = '0;
    initial begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.imem_rvalid = 1'b0;
            if (!reset) begin
                m_pend = 1'b0;
            end else if (m_pend) begin
                if (m_cnt <= 1) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata  = word_at(m_addr);
                    m_pend          = 1'b0;
                end else begin
                    m_cnt--;
                end
            end
            @(negedge clk);
            if (!reset) begin
                m_pend = 1'b0;
            end else if (bus.imem_req) begin
                m_pend = 1'b1;
                m_addr = bus.imem_addr;
                m_cnt  = lat;
            end
        end
    end

    // Scoreboard monitor: every entry IF/ID takes must be the next expected PC
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (reset && bus.if_valid && bus.if_ready && !bus.redirect) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL pop_unexpected: got pc %h expected no entry", bus.if_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_pc", bus.if_pc, e);
                    chk("pop_instr", bus.if_instr, word_at(e));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset           = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.if_ready    = 1'b0;
        repeat (2) step();
    endtask

    task automatic wait_drain(input string name, input int bound);
        int t = 0;
        while (exp_q.size() != 0 && t < bound) begin
            step();
            t++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL %s: %0d entries still pending, required 0 within %0d cycles",
                     name, exp_q.size(), bound);
            exp_q.delete();
        end
        bus.if_ready = 1'b0;
    endtask

    task automatic wait_req(input string name, input int bound, input logic [31:0] exp_addr);
        int t = 0;
        @(negedge clk);
        while (!bus.imem_req && t < bound) begin
            @(negedge clk);
            t++;
        end
        if (!bus.imem_req) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: no imem_req within %0d cycles, required addr %h", name, bound, exp_addr);
        end else begin
            chk(name, bus.imem_addr, exp_addr);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1);
    end

    initial begin
        int nreq;
        int t;

        // ---- 1: reset values, then latency 1 streaming with if_ready=1 ----
        do_reset();
        chk1("rst_if_valid", bus.if_valid, 1'b0);
        chk("rst_if_pc", bus.if_pc, 32'h0);
        chk("rst_if_instr", bus.if_instr, NOP);
        chk1("rst_imem_req", bus.imem_req, 1'b0);
        chk("rst_count", 32'(ifq_count), 32'd0);

        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
        lat          = 1;
        bus.if_ready = 1'b1;
        reset        = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk1("t1_req", bus.imem_req, 1'b1);
            chk("t1_addr", bus.imem_addr, 32'(4 * k));
            if (k == 1) chk1("t1_valid_c1", bus.if_valid, 1'b0);
            if (k == 2) chk1("t1_valid_c2", bus.if_valid, 1'b1);
            step();
        end
        wait_drain("t1_drain", 20);

        // ---- 2: if_ready held low fills the queue, then drains in order ----
        do_reset();
        lat   = 1;
        reset = 1'b1;
        nreq  = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.imem_req) begin
                chk("t2_addr", bus.imem_addr, 32'(4 * nreq));
                nreq++;
            end
            step();
        end
        chk("t2_nreq", 32'(nreq), 32'd4);
        @(negedge clk);
        chk("t2_count_full", 32'(ifq_count), 32'd4);
        chk1("t2_no_req_full", bus.imem_req, 1'b0);
        step();
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
        bus.if_ready = 1'b1;
        wait_req("t2_resume_addr", 10, 32'h10);
        wait_drain("t2_drain", 30);

        // ---- 3: latency 3, redirect to 0x103 while a fetch is outstanding ----
        do_reset();
        lat   = 3;
        reset = 1'b1;
        @(negedge clk);
        chk("t3_first_addr", bus.imem_addr, 32'h0);
        step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0103;
        @(negedge clk);
        chk1("t3_no_req_redirect", bus.imem_req, 1'b0);
        step();
        bus.redirect = 1'b0;
        exp_q = '{32'h100, 32'h104};
        bus.if_ready = 1'b1;
        @(negedge clk);
        chk("t3_count_flushed", 32'(ifq_count), 32'd0);
        chk1("t3_no_req_drop", bus.imem_req, 1'b0);
        wait_req("t3_next_addr", 20, 32'h100);
        chk("t3_stale_not_pushed", 32'(ifq_count), 32'd0);
        wait_drain("t3_drain", 40);

        // ---- 4: redirect coincident with rvalid and a pop ----
        do_reset();
        lat   = 1;
        reset = 1'b1;
        for (t = 0; t < 20; t++) begin
            step();
            if (bus.imem_rvalid && ifq_count == 3'd2) break;
        end
        chk("t4_setup", 32'(ifq_count), 32'd2);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0200;
        bus.if_ready    = 1'b1;
        exp_q = '{32'h200, 32'h204};
        @(negedge clk);
        chk1("t4_no_req_redirect", bus.imem_req, 1'b0);
        step();
        bus.redirect = 1'b0;
        @(negedge clk);
        chk("t4_count_zero", 32'(ifq_count), 32'd0);
        chk1("t4_valid_zero", bus.if_valid, 1'b0);
        chk("t4_instr_nop", bus.if_instr, NOP);
        chk1("t4_req", bus.imem_req, 1'b1);
        chk("t4_req_addr", bus.imem_addr, 32'h200);
        wait_drain("t4_drain", 30);

        // ---- 5: asynchronous reset while WAIT with 3 entries queued ----
        do_reset();
        lat   = 3;
        reset = 1'b1;
        for (t = 0; t < 40; t++) begin
            step();
            if (ifq_count == 3'd3) break;
        end
        chk("t5_fill", 32'(ifq_count), 32'd3);
        reset = 1'b0;
        #1;
        chk1("t5_rst_valid", bus.if_valid, 1'b0);
        chk("t5_rst_pc", bus.if_pc, 32'h0);
        chk("t5_rst_instr", bus.if_instr, NOP);
        chk1("t5_rst_req", bus.imem_req, 1'b0);
        chk("t5_rst_count", 32'(ifq_count), 32'd0);
        step();
        lat   = 1;
        reset = 1'b1;
        exp_q = '{32'h0, 32'h4};
        bus.if_ready = 1'b1;
        @(negedge clk);
        chk1("t5_req_after_rst", bus.imem_req, 1'b1);
        chk("t5_addr_after_rst", bus.imem_addr, RESET_PC);
        wait_drain("t5_drain", 20);

        // ---- 7: redirect from IDLE when full; unaligned target, pc wraps ----
        for (t = 0; t < 30; t++) begin
            step();
            if (ifq_count == 3'd4) break;
        end
        chk("t7_full", 32'(ifq_count), 32'd4);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFE;
        exp_q = '{32'hFFFF_FFFC, 32'h0, 32'h4};
        bus.if_ready = 1'b1;
        @(negedge clk);
        chk1("t7_no_req_redirect", bus.imem_req, 1'b0);
        step();
        bus.redirect = 1'b0;
        @(negedge clk);
        chk("t7_count_zero", 32'(ifq_count), 32'd0);
        chk("t7_req_addr", bus.imem_addr, 32'hFFFF_FFFC);
        wait_drain("t7_drain", 30);

`ifdef IFQ_PERF_EN
        // ---- 6: 2 redirect cycles and 5 starved cycles ----
        do_reset();
        chk("t6_rst_flush", perf_flush_cnt, 32'd0);
        chk("t6_rst_starve", perf_starve_cnt, 32'd0);
        lat   = 20;
        reset = 1'b1;
        step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0040;
        step();
        bus.redirect = 1'b0;
        step();
        bus.redirect = 1'b1;
        step();
        bus.redirect = 1'b0;
        bus.if_ready = 1'b1;
        repeat (5) step();
        bus.if_ready = 1'b0;
        @(negedge clk);
        chk("t6_flush_cnt", perf_flush_cnt, 32'd2);
        chk("t6_starve_cnt", perf_starve_cnt, 32'd5);
`else
`endif

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
